imm_gen_stage: RTL and testbench

- Pipelined, parametrised immediate-generation stage between fetch/decode and issue.
- Decodes the immediate from a 32-bit RV instruction and sign-extends it to XLEN.
- Reports the immediate format and carries a sideband tag through the stage.
- Registered output with a 2-entry skid buffer: full-throughput valid/ready on both sides, and in_ready is driven from a register.

---
 rtl/imm_gen_stage_if.sv | 26 ++
 rtl/imm_gen_stage.sv | 150 +++++++++++++++
 tb/tb_imm_gen_stage.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_stage_if.sv
// Stream bundle for imm_gen_stage: instruction beats in, decoded immediate beats out.
// The slave modport is the stage itself; master is whoever surrounds it.
interface imm_gen_stage_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_fmt;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_instr, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_tag
   );

   modport slave (
      input  in_valid, in_instr, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_tag
   );
endinterface

// File: rtl/imm_gen_stage.sv
// RV immediate decoder with a registered output and a 2-entry skid buffer.
// Optional macro IMM_GEN_CSR_ZIMM_EN: decode csrr*i (opcode 115, funct3 5..7) as fmt Z.
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input logic           clk,
   input logic           rst,
   input logic           flush,
   imm_gen_stage_if.slave bus
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_CSR_ZIMM_EN
   localparam logic [2:0] FMT_Z    = 3'd6;
`endif

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("imm_gen_stage: TAG_W must be at least 1");
   end

   logic [31:0]      instr;
   logic [31:0]      imm32;
   logic [2:0]       dec_fmt;
   logic [XLEN-1:0]  dec_imm;

   logic             m_valid;
   logic [XLEN-1:0]  m_imm;
   logic [2:0]       m_fmt;
   logic [TAG_W-1:0] m_tag;

   logic             k_valid;
   logic [XLEN-1:0]  k_imm;
   logic [2:0]       k_fmt;
   logic [TAG_W-1:0] k_tag;

   logic             rdy_q;
   logic             accept;
   logic             drain;

   assign instr = bus.in_instr;

   // The zero-extended Z immediate has bit 31 clear, so one sign-extending widen serves all formats.
   always_comb begin
      imm32   = 32'd0;
      dec_fmt = FMT_NONE;
      unique case (instr[6:0])
         7'd3, 7'd19, 7'd103: begin
            imm32   = {{20{instr[31]}}, instr[31:20]};
            dec_fmt = FMT_I;
         end
         7'd115: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
            if (instr[14:12] >= 3'd5) begin
               imm32   = {27'd0, instr[19:15]};
               dec_fmt = FMT_Z;
            end else begin
               imm32   = {{20{instr[31]}}, instr[31:20]};
               dec_fmt = FMT_I;
            end
`else
            imm32   = {{20{instr[31]}}, instr[31:20]};
            dec_fmt = FMT_I;
`endif
         end
         7'd35: begin
            imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            dec_fmt = FMT_S;
         end
         7'd99: begin
            imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            dec_fmt = FMT_B;
         end
         7'd55, 7'd23: begin
            imm32   = {instr[31:12], 12'd0};
            dec_fmt = FMT_U;
         end
         7'd111: begin
            imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            dec_fmt = FMT_J;
         end
         default: begin
            imm32   = 32'd0;
            dec_fmt = FMT_NONE;
         end
      endcase
   end

   assign dec_imm = XLEN'(signed'(imm32));

   assign accept = bus.in_valid & rdy_q;
   assign drain  = m_valid & bus.out_ready;

   // K only ever fills while M is held, so K is always the younger beat and refills M first.
   // rdy_q tracks !k_valid as its own flop so in_ready never sees combinational logic.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_imm   <= '0;
         m_fmt   <= FMT_NONE;
         m_tag   <= '0;
         k_valid <= 1'b0;
         k_imm   <= '0;
         k_fmt   <= FMT_NONE;
         k_tag   <= '0;
         rdy_q   <= 1'b1;
      end else if (flush) begin
         m_valid <= 1'b0;
         k_valid <= 1'b0;
         rdy_q   <= 1'b1;
      end else if (!m_valid || drain) begin
         if (k_valid) begin
            m_valid <= 1'b1;
            m_imm   <= k_imm;
            m_fmt   <= k_fmt;
            m_tag   <= k_tag;
            k_valid <= 1'b0;
            rdy_q   <= 1'b1;
         end else if (accept) begin
            m_valid <= 1'b1;
            m_imm   <= dec_imm;
            m_fmt   <= dec_fmt;
            m_tag   <= bus.in_tag;
         end else begin
            m_valid <= 1'b0;
         end
      end else if (accept) begin
         k_valid <= 1'b1;
         k_imm   <= dec_imm;
         k_fmt   <= dec_fmt;
         k_tag   <= bus.in_tag;
         rdy_q   <= 1'b0;
      end
   end

   assign bus.in_ready  = rdy_q;
   assign bus.out_valid = m_valid;
   assign bus.out_imm   = m_imm;
   assign bus.out_fmt   = m_fmt;
   assign bus.out_tag   = m_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Drives an XLEN=32 and an XLEN=64 imm_gen_stage with identical beats and checks both
// against an arithmetic reference decode and an occupancy/order scoreboard.
module tb_imm_gen_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [7:0]  in_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   imm_gen_stage_if #(.XLEN(32), .TAG_W(8)) bus32 ();
   imm_gen_stage_if #(.XLEN(64), .TAG_W(8)) bus64 ();

   assign bus32.in_valid  = in_valid;
   assign bus32.in_instr  = in_instr;
   assign bus32.in_tag    = in_tag;
   assign bus32.out_ready = out_ready;
   assign bus64.in_valid  = in_valid;
   assign bus64.in_instr  = in_instr;
   assign bus64.in_tag    = in_tag;
   assign bus64.out_ready = out_ready;

   imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(bus32));
   imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(bus64));

   logic [117:0] obs_data;
   logic [3:0]   obs_ctl;
   assign obs_data = {bus64.out_imm, bus32.out_imm, bus64.out_fmt, bus32.out_fmt, bus64.out_tag, bus32.out_tag};
   assign obs_ctl  = {bus64.out_valid, bus32.out_valid, bus64.in_ready, bus32.in_ready};

   function automatic logic [3:0] ctl(input logic v, input logic r);
      return {v, v, r, r};
   endfunction

   function automatic longint fld(input logic [31:0] i, input int hi, input int lo);
      return (longint'(i) >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
   endfunction

   function automatic int ref_fmt(input logic [31:0] i);
      case (int'(i[6:0]))
         3, 19, 103: return 1;
`ifdef IMM_GEN_CSR_ZIMM_EN
         115: return (fld(i, 14, 12) >= 5) ? 6 : 1;
`else
         115: return 1;
`endif
         35: return 2;
         99: return 3;
         55, 23: return 4;
         111: return 5;
         default: return 0;
      endcase
   endfunction

   // s is the whole word sign-extended, so arithmetic shifts of s give the sign-filled upper bits.
   function automatic longint ref_imm(input logic [31:0] i);
      longint s;
      s = longint'(signed'(i));
      case (ref_fmt(i))
         1: return s >>> 20;
         2: return ((s >>> 25) << 5) | fld(i, 11, 7);
         3: return ((s >>> 31) << 12) | (fld(i, 7, 7) << 11) | (fld(i, 30, 25) << 5) | (fld(i, 11, 8) << 1);
         4: return s & longint'(-4096);
         5: return ((s >>> 31) << 20) | (fld(i, 19, 12) << 12) | (fld(i, 20, 20) << 11) | (fld(i, 30, 21) << 1);
         6: return fld(i, 19, 15);
         default: return 0;
      endcase
   endfunction

   function automatic logic [117:0] exp_beat(input logic [31:0] i, input logic [7:0] t);
      longint     v;
      logic [2:0] f;
      v = ref_imm(i);
      f = 3'(ref_fmt(i));
      return {64'(v), 32'(v), f, f, t, t};
   endfunction

   function automatic logic [31:0] rand_instr();
      int          opc[9] = '{3, 19, 103, 115, 35, 99, 55, 23, 111};
      logic [31:0] r;
      int          idx;
      r   = $urandom;
      idx = $urandom_range(0, 9);
      if (idx < 9) r[6:0] = 7'(opc[idx]);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = '0; in_tag = '0;
      #12;
      checks++;
      if (obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL reset_ctl got %b want %b", obs_ctl, ctl(1'b0, 1'b1));
      end
      checks++;
      if (obs_data !== '0) begin
         errors++; $display("[TB] FAIL reset_data got %h want 0", obs_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_addi();
      logic [117:0] want;
      want = {64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 3'd1, 8'h11, 8'h11};
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_tag = 8'h11;
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b1)) begin
         errors++; $display("[TB] FAIL addi_ctl got %b want %b", obs_ctl, ctl(1'b1, 1'b1));
      end
      checks++;
      if (obs_data !== want) begin
         errors++; $display("[TB] FAIL addi_data got %h want %h", obs_data, want);
      end
      tick();
      checks++;
      if (obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL addi_drained got %b want %b", obs_ctl, ctl(1'b0, 1'b1));
      end
   endtask

   task automatic test_xlen64();
      logic [117:0] want;
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h8000_00B7; in_tag = 8'h21;
      tick();
      in_instr = 32'hFE00_0EE3; in_tag = 8'h22;
      want = {64'hFFFF_FFFF_8000_0000, 32'h8000_0000, 3'd4, 3'd4, 8'h21, 8'h21};
      checks++;
      if (obs_data !== want) begin
         errors++; $display("[TB] FAIL lui_data got %h want %h", obs_data, want);
      end
      tick();
      in_valid = 1'b0;
      want = {64'hFFFF_FFFF_FFFF_FFFC, 32'hFFFF_FFFC, 3'd3, 3'd3, 8'h22, 8'h22};
      checks++;
      if (obs_data !== want || obs_ctl !== ctl(1'b1, 1'b1)) begin
         errors++; $display("[TB] FAIL beq_data got %h/%b want %h/%b", obs_data, obs_ctl, want, ctl(1'b1, 1'b1));
      end
      tick();
   endtask

   task automatic test_backpressure();
      logic [117:0] w_s, w_j, w_n;
      w_s = {64'd8, 32'd8, 3'd2, 3'd2, 8'h01, 8'h01};
      w_j = {64'd0, 32'd0, 3'd5, 3'd5, 8'h02, 8'h02};
      w_n = {64'd0, 32'd0, 3'd0, 3'd0, 8'h03, 8'h03};
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0011_2423; in_tag = 8'h01;
      tick();
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b1)) begin
         errors++; $display("[TB] FAIL bp_first got %b want %b", obs_ctl, ctl(1'b1, 1'b1));
      end
      in_instr = 32'h0000_006F; in_tag = 8'h02;
      tick();
      in_instr = 32'h0000_007F; in_tag = 8'h03;
      tick();
      tick();
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b0) || obs_data !== w_s) begin
         errors++; $display("[TB] FAIL bp_full got %b/%h want %b/%h", obs_ctl, obs_data, ctl(1'b1, 1'b0), w_s);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b1) || obs_data !== w_j) begin
         errors++; $display("[TB] FAIL bp_second got %b/%h want %b/%h", obs_ctl, obs_data, ctl(1'b1, 1'b1), w_j);
      end
      tick();
      in_valid = 1'b0;
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b1) || obs_data !== w_n) begin
         errors++; $display("[TB] FAIL bp_third got %b/%h want %b/%h", obs_ctl, obs_data, ctl(1'b1, 1'b1), w_n);
      end
      tick();
      checks++;
      if (obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL bp_empty got %b want %b", obs_ctl, ctl(1'b0, 1'b1));
      end
   endtask

   task automatic test_throughput();
      logic [117:0] q[$];
      logic [117:0] want;
      int           outs = 0;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 17; cyc++) begin
         in_valid = (cyc < 16);
         in_instr = rand_instr();
         in_tag   = 8'($urandom);
         if (bus32.out_valid) begin
            outs++;
            want = (q.size() > 0) ? q.pop_front() : '0;
            checks++;
            if (obs_data !== want) begin
               errors++; $display("[TB] FAIL tp_beat%0d got %h want %h", outs, obs_data, want);
            end
         end
         checks++;
         if (obs_ctl[1:0] !== 2'b11) begin
            errors++; $display("[TB] FAIL tp_ready cycle %0d got %b want 11", cyc, obs_ctl[1:0]);
         end
         if (in_valid) q.push_back(exp_beat(in_instr, in_tag));
         tick();
      end
      in_valid = 1'b0;
      checks++;
      if (outs != 16 || q.size() != 0 || obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL tp_count got %0d outs left %0d ctl %b want 16 outs left 0", outs, q.size(), obs_ctl);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_0013; in_tag = 8'hA1;
      tick();
      in_instr = 32'h0000_0037; in_tag = 8'hA2;
      tick();
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b0)) begin
         errors++; $display("[TB] FAIL flush_prefill got %b want %b", obs_ctl, ctl(1'b1, 1'b0));
      end
      in_instr = 32'h0000_006F; in_tag = 8'hA3; flush = 1'b1;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      checks++;
      if (obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL flush_clear got %b want %b", obs_ctl, ctl(1'b0, 1'b1));
      end
      out_ready = 1'b1;
      for (int n = 0; n < 3; n++) begin
         tick();
         checks++;
         if (obs_ctl !== ctl(1'b0, 1'b1)) begin
            errors++; $display("[TB] FAIL flush_ghost cycle %0d got %b want %b", n, obs_ctl, ctl(1'b0, 1'b1));
         end
      end
      // flush beside a live downstream handshake still wins
      in_valid = 1'b1; in_instr = 32'h0000_0023; in_tag = 8'hA4;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL flush_with_drain got %b want %b", obs_ctl, ctl(1'b0, 1'b1));
      end
   endtask

   task automatic test_async_reset_csr();
      logic [117:0] want;
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000_0063; in_tag = 8'hB1;
      tick();
      in_instr = 32'h0000_0003; in_tag = 8'hB2;
      tick();
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      checks++;
      if (obs_ctl !== ctl(1'b0, 1'b1) || obs_data !== '0) begin
         errors++; $display("[TB] FAIL async_reset got %b/%h want %b/0", obs_ctl, obs_data, ctl(1'b0, 1'b1));
      end
      tick();
      #2 rst = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h3401_D073; in_tag = 8'h5A;
      tick();
      in_valid = 1'b0;
`ifdef IMM_GEN_CSR_ZIMM_EN
      want = {64'd3, 32'd3, 3'd6, 3'd6, 8'h5A, 8'h5A};
`else
      want = {64'h340, 32'h340, 3'd1, 3'd1, 8'h5A, 8'h5A};
`endif
      checks++;
      if (obs_ctl !== ctl(1'b1, 1'b1) || obs_data !== want) begin
         errors++; $display("[TB] FAIL csr_imm got %b/%h want %b/%h", obs_ctl, obs_data, ctl(1'b1, 1'b1), want);
      end
      tick();
   endtask

   // Scoreboard: the stage is a 2-deep FIFO with a flush, nothing more.
   task automatic test_random_stress();
      logic [117:0] q[$];
      logic [117:0] want;
      int           sz;
      for (int cyc = 0; cyc < 320; cyc++) begin
         if (cyc < 300) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
         end else begin
            in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
         end
         in_instr = rand_instr();
         in_tag   = 8'($urandom);
         sz = q.size();
         checks++;
         if (obs_ctl !== ctl(sz > 0, sz < 2)) begin
            errors++; $display("[TB] FAIL rnd_ctl cycle %0d got %b want %b", cyc, obs_ctl, ctl(sz > 0, sz < 2));
         end
         if (sz > 0 && out_ready) begin
            want = q.pop_front();
            checks++;
            if (obs_data !== want) begin
               errors++; $display("[TB] FAIL rnd_beat cycle %0d got %h want %h", cyc, obs_data, want);
            end
         end
         if (flush) q.delete();
         else if (in_valid && sz < 2) q.push_back(exp_beat(in_instr, in_tag));
         tick();
      end
      checks++;
      if (q.size() != 0 || obs_ctl !== ctl(1'b0, 1'b1)) begin
         errors++; $display("[TB] FAIL rnd_final left %0d ctl %b want 0 %b", q.size(), obs_ctl, ctl(1'b0, 1'b1));
      end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_xlen64();
      test_backpressure();
      test_throughput();
      test_flush();
      test_async_reset_csr();
      test_random_stress();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

endmodule
